pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencer for the five-stage core.
- Collects stall requests from fetch, decode and execute, detects load-use hazards that the decode forwarding paths cannot cover, and sequences exception flushes.
- Drives one stall vector and one flush strobe to all pipeline registers and the PC.
- Keeps a saturating stall-cycle counter and a multi-cycle-stall watchdog.

Parameters:
- FLUSH_CYCLES, 1, total cycles flush_o stays high per accepted flush (>=1).
- STALL_TIMEOUT, 1024, consecutive ex_stallreq_i cycles before timeout_o sets (>=2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- id_reg1_read_i  in  1  decode reads operand 1 from the register file.
- id_reg1_addr_i  in  5  decode operand 1 address.
- id_reg2_read_i  in  1  decode reads operand 2 from the register file.
- id_reg2_addr_i  in  5  decode operand 2 address.
- ex_is_load_i  in  1  instruction in execute is a load.
- ex_wreg_i  in  1  execute instruction writes a register.
- ex_wd_i  in  5  execute destination register.
- ex_stallreq_i  in  1  multi-cycle execute op (mul/div) busy.
- if_stallreq_i  in  1  fetch waiting on instruction memory.
- flush_req_i  in  1  exception/eret flush request.
- flush_pc_i  in  32  handler/return PC accompanying flush_req_i.
- stall_o  out  6  stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
- flush_o  out  1  clear all pipeline registers.
- new_pc_o  out  32  PC to load while flush_o is high.
- timeout_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o[0]==1.

Behaviour:
- Reset (rst==0, asynchronous):
  - stall_o=0, flush_o=0, new_pc_o=0, timeout_o=0, stall_cnt_o=0.
  - FSM goes to RUN; watchdog and flush counters clear.
  - stall_o and flush_o are gated to 0 combinationally while rst==0.
- Load-use detection is combinational:
  - load_use = ex_is_load_i & ex_wreg_i & (ex_wd_i!=0) & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)).
- stall_o is combinational from the requests and the current state, with zero-cycle latency, because the pipeline registers sample it the same edge. Priority, highest first:
  - Flush active (flush_req_i in RUN/MULTI, or state FLUSH): stall_o=6'b000000.
  - ex_stallreq_i: 6'b001111.
  - load_use: 6'b000111. Execute receives a bubble, so the load advances and the hazard clears the next cycle.
  - if_stallreq_i: 6'b000011.
  - Otherwise: 6'b000000.
- FSM states RUN, MULTI, FLUSH:
  - RUN:
    - flush_req_i: flush_o=1 combinationally; new_pc_o=flush_pc_i (pass-through this cycle, also registered); go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
    - ex_stallreq_i (no flush): go to MULTI, watchdog=1.
  - MULTI:
    - flush_req_i handled exactly as in RUN; watchdog clears.
    - ex_stallreq_i high: watchdog increments, saturating at STALL_TIMEOUT. On reaching STALL_TIMEOUT, timeout_o sets and stays set until reset; the stall continues.
    - ex_stallreq_i low: go to RUN, watchdog=0.
  - FLUSH:
    - flush_o=1 and new_pc_o holds the registered PC; all stall requests are ignored.
    - Exit to RUN after FLUSH_CYCLES total flush cycles.
    - A new flush_req_i in FLUSH restarts the count and loads the new flush_pc_i (that cycle drives the new PC).
- Outside flush, new_pc_o holds its last value; consumers qualify it with flush_o.
- stall_cnt_o increments at each clock edge where stall_o[0]==1; it saturates at all-ones and never wraps.
- Simultaneous events:
  - flush beats every stall.
  - ex_stallreq_i together with load_use yields 001111.
  - Register 0 never causes a load-use stall.
- Reset asserted mid-FLUSH or mid-MULTI aborts immediately to the reset values; timeout_o clears.

Decomposition:
- Shared defines: stall vector encodings (STALL_NONE, STALL_IF=6'b000011, STALL_ID=6'b000111, STALL_EX=6'b001111), stall bit indices, FSM state codes, FlushEnable/FlushDisable.
- One natural sub-module: hazard_detect (the combinational load_use compare).
- FSM, watchdog and counter stay in pipe_ctrl.

Test Plan:
- Load-use: ex_is_load_i=1, ex_wreg_i=1, ex_wd_i=5, id_reg2_read_i=1, id_reg2_addr_i=5 for 1 cycle -> stall_o=000111 that cycle, 000000 after; stall_cnt_o +1. Same stimulus with ex_wd_i=0 -> stall_o=000000.
- Multi-cycle: ex_stallreq_i high 10 cycles while if_stallreq_i=1 -> stall_o=001111 for 10 cycles, then 000011; stall_cnt_o +10 during the multi-cycle stall.
- Watchdog: STALL_TIMEOUT=4, ex_stallreq_i held 6 cycles -> timeout_o rises in the 4th MULTI cycle and stays 1 after ex_stallreq_i drops; clears only on rst=0.
- Flush: FLUSH_CYCLES=3, flush_req_i pulse with flush_pc_i=0x00000020 during ex_stallreq_i -> flush_o=1 for exactly 3 cycles, new_pc_o=0x20, stall_o=0 throughout. A second flush in cycle 2 with PC 0x40 -> 3 more cycles with 0x40.
- Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt_o=15, no wrap.
- Async reset: drop rst mid-FLUSH between clock edges -> flush_o, stall_o, timeout_o and stall_cnt_o go to 0 immediately; after release the FSM is in RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, bit indices, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Stall vectors: bit 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  // Bit of the stall vector that freezes the PC
  localparam int STALL_PC_BIT = 0;

  localparam logic FLUSH_ENABLE  = 1'b1;
  localparam logic FLUSH_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between decode source operands and the load in execute.
// Latency: combinational, zero cycles.
// Backpressure: none; result feeds the stall priority logic directly.
module pipe_ctrl_hazard_detect (
  input  logic       id_reg1_read_i,
  input  logic [4:0] id_reg1_addr_i,
  input  logic       id_reg2_read_i,
  input  logic [4:0] id_reg2_addr_i,
  input  logic       ex_is_load_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_wd_i,
  output logic       load_use_o
);

  logic hit1;
  logic hit2;

  // Register 0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    hit1       = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
    hit2       = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);
    load_use_o = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) && (hit1 || hit2);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, load-use hazards and exception flushes.
// Latency: stall_o/flush_o zero-cycle combinational; counters/timeout update on the edge.
// Backpressure: stall_o is the backpressure to the pipeline; a flush overrides every stall.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_wreg_i,
  input  logic [4:0]       ex_wd_i,
  input  logic             ex_stallreq_i,
  input  logic             if_stallreq_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_TIMEOUT);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES);

  state_t            state;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_inc;
  logic [FC_W-1:0]   fc_q;
  logic [31:0]       pc_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_use;
  logic              flush_act;
  logic [5:0]        stall_raw;

  pipe_ctrl_hazard_detect u_hazard (
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .load_use_o     (load_use)
  );

  // Stall priority: flush > multi-cycle execute > load-use > fetch wait
  always_comb begin
    flush_act = flush_req_i || (state == ST_FLUSH);
    stall_raw = STALL_NONE;
    if (flush_act)          stall_raw = STALL_NONE;
    else if (ex_stallreq_i) stall_raw = STALL_EX;
    else if (load_use)      stall_raw = STALL_ID;
    else if (if_stallreq_i) stall_raw = STALL_IF;
    wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
  end

  // Outputs are forced idle while reset is held; a new flush PC passes straight through
  always_comb begin
    stall_o   = rst ? stall_raw : STALL_NONE;
    flush_o   = (rst && flush_act) ? FLUSH_ENABLE : FLUSH_DISABLE;
    new_pc_o  = (rst && flush_req_i) ? flush_pc_i : pc_q;
    timeout_o = timeout_q;
    stall_cnt_o = cnt_q;
  end

  // Sequencer FSM: flush hold-off, multi-cycle stall tracking and sticky watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      wd_q      <= '0;
      fc_q      <= '0;
      pc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN, ST_MULTI: begin
          if (flush_req_i) begin
            pc_q  <= flush_pc_i;
            wd_q  <= '0;
            fc_q  <= FC_W'(1);
            state <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else if (ex_stallreq_i) begin
            state <= ST_MULTI;
            if (state == ST_RUN) begin
              wd_q <= WD_W'(1);
            end else begin
              wd_q <= wd_inc;
              if (wd_inc == WD_MAX) timeout_q <= 1'b1;
            end
          end else begin
            state <= ST_RUN;
            wd_q  <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_req_i) begin
            pc_q  <= flush_pc_i;
            fc_q  <= FC_W'(1);
            state <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else if ((fc_q + FC_W'(1)) == FC_LAST) begin
            fc_q  <= '0;
            state <= ST_RUN;
          end else begin
            fc_q  <= fc_q + FC_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (stall_o[STALL_PC_BIT] && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with FLUSH_CYCLES=3, STALL_TIMEOUT=4, CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected stall/flush/pc per cycle go through a scoreboard queue.
module tb_pipe_ctrl;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        chk_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg2_addr_i;
  logic        ex_is_load_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_stallreq_i;
  logic        if_stallreq_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        timeout_o;
  logic [3:0]  stall_cnt_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_stallreq_i  (ex_stallreq_i),
    .if_stallreq_i  (if_stallreq_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic clear_inputs();
    id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
    id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;
    ex_is_load_i   = 1'b0; ex_wreg_i      = 1'b0; ex_wd_i = 5'd0;
    ex_stallreq_i  = 1'b0; if_stallreq_i  = 1'b0;
    flush_req_i    = 1'b0; flush_pc_i     = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    ex_stallreq_i = 1'b1; if_stallreq_i = 1'b1; flush_req_i = 1'b1;
    #3;
    checks++; if (stall_o !== 6'b0) begin errors++; $display("FAIL reset_stall got %b want 000000", stall_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_o); end
    checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h want 0", new_pc_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_o); end
    checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt_o); end
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [5:0] es;
    logic [3:0] ec;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      ex_is_load_i = 1'b1; ex_wreg_i = 1'b1;
      case (c)
        0: begin ex_wd_i = 5'd5; id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd5; es = 6'b000111; ec = 4'd0; end
        1: begin ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; es = 6'b000000; ec = 4'd1; end
        2: begin ex_wd_i = 5'd0; id_reg2_read_i = 1'b1; id_reg1_read_i = 1'b1; es = 6'b000000; ec = 4'd1; end
        3: begin ex_wd_i = 5'd9; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd9; es = 6'b000111; ec = 4'd1; end
        4: begin ex_wd_i = 5'd9; id_reg1_addr_i = 5'd9; id_reg2_addr_i = 5'd9; es = 6'b000000; ec = 4'd2; end
        default: begin ex_is_load_i = 1'b0; ex_wd_i = 5'd9; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd9; es = 6'b000000; ec = 4'd2; end
      endcase
      exp_q.push_back('{es, 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_o, flush_o} !== {e.stall, e.flush}) begin
        errors++; $display("FAIL load_use cyc %0d got stall=%b flush=%b want stall=%b flush=%b", c, stall_o, flush_o, e.stall, e.flush);
      end
      checks++;
      if (stall_cnt_o !== ec) begin errors++; $display("FAIL load_use_cnt cyc %0d got %0d want %0d", c, stall_cnt_o, ec); end
      tick();
    end
  endtask

  task automatic test_multi();
    exp_t e;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      if (c < 10) ex_stallreq_i = 1'b1;
      if (c < 11) if_stallreq_i = 1'b1;
      if (c == 0) begin
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd7;
        id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd7;
      end
      exp_q.push_back('{(c < 10) ? 6'b001111 : ((c == 10) ? 6'b000011 : 6'b000000), 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_o, flush_o} !== {e.stall, e.flush}) begin
        errors++; $display("FAIL multi cyc %0d got stall=%b flush=%b want stall=%b flush=%b", c, stall_o, flush_o, e.stall, e.flush);
      end
      checks++;
      if (stall_cnt_o !== 4'(c)) begin errors++; $display("FAIL multi_cnt cyc %0d got %0d want %0d", c, stall_cnt_o, c); end
      tick();
    end
  endtask

  task automatic test_watchdog();
    exp_t e;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      ex_stallreq_i = (c < 6);
      exp_q.push_back('{(c < 6) ? 6'b001111 : 6'b000000, 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (stall_o !== e.stall) begin errors++; $display("FAIL wd_stall cyc %0d got %b want %b", c, stall_o, e.stall); end
      checks++;
      if (timeout_o !== (c >= 4)) begin errors++; $display("FAIL wd_timeout cyc %0d got %b want %b", c, timeout_o, (c >= 4)); end
      tick();
    end
    rst = 1'b0;
    #2;
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", timeout_o); end
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      ex_stallreq_i = 1'b1;
      flush_pc_i    = 32'hDEAD_BEEF;
      case (c)
        0:       exp_q.push_back('{6'b001111, 1'b0, 32'h0, 1'b0});
        1, 5:    begin flush_req_i = 1'b1; flush_pc_i = 32'h20; exp_q.push_back('{6'b0, 1'b1, 32'h20, 1'b1}); end
        2, 3:    exp_q.push_back('{6'b0, 1'b1, 32'h20, 1'b1});
        4:       exp_q.push_back('{6'b001111, 1'b0, 32'h20, 1'b1});
        6:       begin flush_req_i = 1'b1; flush_pc_i = 32'h40; exp_q.push_back('{6'b0, 1'b1, 32'h40, 1'b1}); end
        7, 8:    exp_q.push_back('{6'b0, 1'b1, 32'h40, 1'b1});
        default: exp_q.push_back('{6'b001111, 1'b0, 32'h40, 1'b1});
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_o, flush_o} !== {e.stall, e.flush}) begin
        errors++; $display("FAIL flush cyc %0d got stall=%b flush=%b want stall=%b flush=%b", c, stall_o, flush_o, e.stall, e.flush);
      end
      if (e.chk_pc) begin
        checks++;
        if (new_pc_o !== e.pc) begin errors++; $display("FAIL flush_pc cyc %0d got %h want %h", c, new_pc_o, e.pc); end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int c = 0; c < 21; c++) begin
      clear_inputs();
      if_stallreq_i = (c < 20);
      exp_q.push_back('{(c < 20) ? 6'b000011 : 6'b000000, 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (stall_o !== e.stall) begin errors++; $display("FAIL sat_stall cyc %0d got %b want %b", c, stall_o, e.stall); end
      checks++;
      if (stall_cnt_o !== 4'((c > 15) ? 15 : c)) begin
        errors++; $display("FAIL sat_cnt cyc %0d got %0d want %0d", c, stall_cnt_o, (c > 15) ? 15 : c);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      if (c < 5) begin
        ex_stallreq_i = 1'b1;
        exp_q.push_back('{6'b001111, 1'b0, 32'h0, 1'b0});
      end else begin
        ex_stallreq_i = (c == 6);
        if_stallreq_i = (c == 6);
        flush_req_i   = (c == 5);
        flush_pc_i    = 32'h80;
        exp_q.push_back('{6'b0, 1'b1, 32'h80, 1'b1});
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_o, flush_o} !== {e.stall, e.flush}) begin
        errors++; $display("FAIL arst_pre cyc %0d got stall=%b flush=%b want stall=%b flush=%b", c, stall_o, flush_o, e.stall, e.flush);
      end
      if (c < 6) tick();
    end
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL arst_timeout_set got %b want 1", timeout_o); end
    checks++; if (stall_cnt_o !== 4'd5) begin errors++; $display("FAIL arst_cnt_set got %0d want 5", stall_cnt_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL arst_flush got %b want 0", flush_o); end
    checks++; if (stall_o !== 6'b0) begin errors++; $display("FAIL arst_stall got %b want 000000", stall_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL arst_timeout got %b want 0", timeout_o); end
    checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", stall_cnt_o); end
    checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL arst_new_pc got %h want 0", new_pc_o); end
    tick();
    rst = 1'b1;
    clear_inputs();
    ex_stallreq_i = 1'b1;
    exp_q.push_back('{6'b001111, 1'b0, 32'h0, 1'b0});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({stall_o, flush_o} !== {e.stall, e.flush}) begin
      errors++; $display("FAIL arst_run got stall=%b flush=%b want stall=%b flush=%b", stall_o, flush_o, e.stall, e.flush);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multi();
    test_watchdog();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
